// File: rtl/contador_pkg.sv
// Shared frame constants for blocks that instantiate the I2C bit-position
// counter (contador_rst).
package contador_pkg;

  // 8 data bits plus the ACK slot.
  localparam int I2C_FRAME_LEN = 9;
  localparam int CNT_W         = 4;

endpackage : contador_pkg

// File: rtl/contador_rst.sv
// Enabled modulo-N up-counter with asynchronous active-low reset (I2C bit position).
// Optional registered terminal-count output Tc when CONTADOR_RST_TC_EN is defined.
module contador_rst
  import contador_pkg::*;
#(
  parameter int N     = I2C_FRAME_LEN,
  parameter int WIDTH = CNT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  output logic [WIDTH-1:0] Out
`ifdef CONTADOR_RST_TC_EN
  ,
  output logic             Tc
`endif
);

  if (N < 2 || N >= (1 << WIDTH)) begin : g_bad_param
    $fatal(1, "contador_rst: N=%0d out of range 2..%0d for WIDTH=%0d",
           N, (1 << WIDTH) - 1, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_next;

  // Values above N can only come from a glitch; they recover to 1 like a wrap.
  always_comb begin
    cnt_next = Out;
    if (En) begin
      cnt_next = (Out >= LAST) ? ONE : Out + ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Out <= '0;
    end else begin
      Out <= cnt_next;
    end
  end

`ifdef CONTADOR_RST_TC_EN
  // Registered from the next count so Tc changes on the same edge as Out.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Tc <= 1'b0;
    end else begin
      Tc <= (cnt_next == LAST);
    end
  end
`endif

endmodule : contador_rst

// File: tb/tb_contador_rst.sv
// Self-checking bench for contador_rst: N=9/WIDTH=4 and N=3/WIDTH=2 instances
// checked against a frame-position reference model. Checks Tc when CONTADOR_RST_TC_EN is set.
module tb_contador_rst;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       En  = 1'b0;
  logic [3:0] out9;
  logic [1:0] out3;
`ifdef CONTADOR_RST_TC_EN
  logic       tc9;
  logic       tc3;
`endif

  int errors = 0;
  int checks = 0;
  int pos9   = 0;
  int pos3   = 0;

  always #5 Clk = ~Clk;

  contador_rst #(.N(9), .WIDTH(4)) dut9 (
    .Clk(Clk),
    .Rst(Rst),
    .En (En),
    .Out(out9)
`ifdef CONTADOR_RST_TC_EN
    ,
    .Tc (tc9)
`endif
  );

  contador_rst #(.N(3), .WIDTH(2)) dut3 (
    .Clk(Clk),
    .Rst(Rst),
    .En (En),
    .Out(out3)
`ifdef CONTADOR_RST_TC_EN
    ,
    .Tc (tc3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame positions run 1..n repeating; 0 appears only after reset.
  function automatic int next_pos(input int pos, input int n);
    return (pos % n) + 1;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/n9"}, 32'(out9), 32'(pos9));
    check({tag, "/n3"}, 32'(out3), 32'(pos3));
`ifdef CONTADOR_RST_TC_EN
    check({tag, "/tc9"}, 32'(tc9), 32'(pos9 == 9));
    check({tag, "/tc3"}, 32'(tc3), 32'(pos3 == 3));
`endif
  endtask

  // Drive En mid-cycle, take one rising edge, check 1 time unit later.
  task automatic tick(input logic en, input string tag);
    En = en;
    @(posedge Clk);
    if (Rst && en) begin
      pos9 = next_pos(pos9, 9);
      pos3 = next_pos(pos3, 3);
    end
    #1;
    check_all(tag);
  endtask

  // Reset pulse between edges; Out must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    Rst = 1'b0;
    #1;
    pos9 = 0;
    pos3 = 0;
    check_all("async_rst");
    #4;
    Rst = 1'b1;
  endtask

  initial begin
    // Held in reset with En high: edges must not count.
    Rst = 1'b0;
    #2;
    check_all("rst_init");
    for (int i = 0; i < 4; i++) tick(1'b1, "rst_hold");

    // Release between edges, then 20 enabled edges: 1..9,1..9,1,2.
    #2;
    Rst = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b1, "wrap");
    check("wrap_end9", 32'(out9), 32'd2);

    // Enable hold at 5.
    async_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, "to5");
    for (int i = 0; i < 3; i++) tick(1'b0, "hold");
    check("hold_val", 32'(out9), 32'd5);
    tick(1'b1, "resume");
    check("resume_val", 32'(out9), 32'd6);

    // Mid-count reset at 7, next enabled edge gives 1.
    tick(1'b1, "to7");
    async_reset();
    tick(1'b1, "after_rst");
    check("after_rst_val", 32'(out9), 32'd1);

    // Randomized enable with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) != 0), "rand");
      if ($urandom_range(0, 24) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_contador_rst
